parity_frame_receiver: RTL and testbench
========================================

// Module: parity_frame_receiver
//
// PURPOSE
//   Receiving end of the XOR-parity serial link.
//   - Takes a bit-serial stream: WIDTH data bits, LSB first, then one parity bit.
//   - Rebuilds the data word and checks parity with a running XOR.
//   - Presents the word on a valid/ready output with parity-error and overrun flags.
//   - Sits between the serial line and the word-level consumer.
//
// PARAMETERS
//   WIDTH       8   data bits per frame (>=2)
//   ODD_PARITY  0   0: even parity (XOR of data+parity == 0); 1: odd parity (== 1)
//
// PORTS
//   clk           in   1      clock; all state updates on rising edge
//   reset         in   1      synchronous, active-high reset
//   inBit         in   1      serial bit; sampled only when inValid=1
//   inValid       in   1      inBit carries a frame bit this cycle
//   inStart       in   1      qualified by inValid; marks data bit 0 of a frame
//   outData       out  WIDTH  received word; held stable while outValid=1
//   outValid      out  1      word available; held until accepted
//   outReady      in   1      consumer accepts word when outValid&outReady
//   outParityErr  out  1      parity result for outData; valid while outValid=1
//   outOverrun    out  1      sticky: a completed frame was dropped
//
// BEHAVIOUR
//   - Reset: state IDLE, bit counter 0, parity accumulator 0.
//     All outputs 0 on the cycle after reset is sampled high.
//     Reset mid-frame discards the partial frame and any held word.
//   - States:
//     - IDLE: waits for inValid&inStart.
//     - DATA: shifts in data bits, counter 0..WIDTH-1.
//     - PARITY: takes the single parity bit.
//   - inValid=0: state, counter, shift register and accumulator all hold.
//     Gaps between bits of any length are legal.
//   - IDLE + inValid + !inStart: the bit is ignored.
//   - inValid&inStart in any state (IDLE, DATA or PARITY):
//     - aborts any partial frame;
//     - the bit becomes data bit 0;
//     - accumulator is loaded with inBit, counter is set to 1, next state DATA.
//   - DATA, inValid&!inStart:
//     - inBit goes into bit[counter] and is XORed into the accumulator;
//     - counter increments;
//     - after bit WIDTH-1 is taken, next state PARITY.
//   - PARITY, inValid&!inStart: frame completes.
//     - err = acc ^ inBit ^ ODD_PARITY;
//     - next state IDLE.
//   - Completion load rule (decided on the completion cycle):
//     - If outValid=0, or outValid&outReady in the same cycle:
//       next cycle outData=word, outParityErr=err, outValid=1.
//     - Otherwise: the new word is dropped, the held word is unchanged,
//       and outOverrun goes to 1.
//   - Latency: outValid rises 1 cycle after the parity bit is sampled.
//   - outValid&outReady with no completion: outValid=0 next cycle;
//     outData and outParityErr hold their last values.
//   - outOverrun: cleared only by reset.
//   - A parity error does not block delivery; the word is still presented, with the flag set.
//
// STRUCTURE
//   - Shared include parity_defs.vh:
//     - state encodings S_IDLE=2'd0, S_DATA=2'd1, S_PARITY=2'd2;
//     - PARITY_EVEN=1'b0, PARITY_ODD=1'b1.
//     The matching transmitter uses the same file.
//   - One sub-module, parity_accum:
//     - 1-bit XOR accumulator register;
//     - inputs clk, reset, load, enable, inBit; output acc.
//     Built on the existing Xor gate.
//   - Counter width: $clog2(WIDTH+1).
//
// TESTING
//   Bench uses WIDTH=8, ODD_PARITY=0 unless stated; compare with ===; print PASSED/FAILED per test.
//   T0: reset high for 2 cycles
//       -> outData=0, outValid=0, outParityErr=0, outOverrun=0.
//   T1: outReady=1; bits 1,0,1,0,0,1,0,1 (inStart on first), then parity 0
//       -> next cycle outData=8'hA5, outValid=1, outParityErr=0.
//   T2: same frame, parity 1
//       -> outData=8'hA5, outParityErr=1.
//       Repeat with ODD_PARITY=1 and parity 1 -> outParityErr=0.
//   T3: outReady=0; frame 8'h0F (parity 0), then frame 8'hF0
//       -> outData stays 8'h0F, outOverrun=1.
//       Then outReady=1 -> outValid drops next cycle.
//   T4: start a frame, send 3 bits, then inStart with frame 8'h3C (parity 0);
//       inValid gaps of 1-3 cycles inserted
//       -> single outValid with outData=8'h3C, outParityErr=0.
//   T5: reset asserted after 5 data bits, then parity-position bit sent without inStart
//       -> no outValid; a following full frame 8'h81 (parity 0) is received correctly.

Source files
------------

// File: rtl/parity_frame_receiver_pkg.sv
// Shared definitions for the XOR-parity serial link: receiver state encoding,
// parity-sense constants and the parity check used at frame completion.
package parity_frame_receiver_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2
  } rx_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Nonzero when data XOR parity bit does not match the selected parity sense.
  function automatic logic frame_parity_err(input logic acc, input logic parity_bit,
                                            input logic odd);
    return acc ^ parity_bit ^ odd;
  endfunction

endpackage

// File: rtl/parity_frame_receiver_accum.sv
// One-bit running XOR accumulator: load starts a fresh frame, enable folds in a bit.
module parity_accum (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  input  logic inBit,
  output logic acc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= 1'b0;
    end else if (load) begin
      acc <= inBit;
    end else if (enable) begin
      acc <= acc ^ inBit;
    end
  end

endmodule

// File: rtl/parity_frame_receiver.sv
// Serial frame receiver: WIDTH data bits LSB first plus one parity bit, delivered
// as a word on a valid/ready port with parity-error and sticky overrun flags.
module parity_frame_receiver
  import parity_frame_receiver_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit ODD_PARITY = PARITY_EVEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inBit,
  input  logic             inValid,
  input  logic             inStart,
  output logic [WIDTH-1:0] outData,
  output logic             outValid,
  input  logic             outReady,
  output logic             outParityErr,
  output logic             outOverrun
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  rx_state_e        state, next_state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic             acc;
  logic             acc_load;
  logic             acc_en;
  logic             frame_done;
  logic             frame_err;
  logic             deliver;

  parity_accum u_accum (
    .clk    (clk),
    .reset  (reset),
    .load   (acc_load),
    .enable (acc_en),
    .inBit  (inBit),
    .acc    (acc)
  );

  // A qualified start always wins, restarting the frame from any state.
  always_comb begin
    next_state = state;
    acc_load   = 1'b0;
    acc_en     = 1'b0;
    frame_done = 1'b0;
    if (inValid) begin
      if (inStart) begin
        next_state = S_DATA;
        acc_load   = 1'b1;
      end else begin
        case (state)
          S_DATA: begin
            acc_en = 1'b1;
            if (bit_cnt == LAST_IDX) next_state = S_PARITY;
          end
          S_PARITY: begin
            frame_done = 1'b1;
            next_state = S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign frame_err = frame_parity_err(acc, inBit, ODD_PARITY == PARITY_ODD);
  assign deliver   = frame_done && (!outValid || outReady);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      state <= next_state;
      if (acc_load) begin
        bit_cnt   <= CW'(1);
        shift_reg <= {{(WIDTH-1){1'b0}}, inBit};
      end else if (acc_en) begin
        bit_cnt <= bit_cnt + CW'(1);
        for (int i = 0; i < WIDTH; i++) begin
          if (bit_cnt == CW'(i)) shift_reg[i] <= inBit;
        end
      end
    end
  end

  // A completed frame that finds the output still occupied is dropped and flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      outData      <= '0;
      outValid     <= 1'b0;
      outParityErr <= 1'b0;
      outOverrun   <= 1'b0;
    end else if (deliver) begin
      outData      <= shift_reg;
      outParityErr <= frame_err;
      outValid     <= 1'b1;
    end else begin
      if (frame_done) outOverrun <= 1'b1;
      if (outValid && outReady) outValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_parity_frame_receiver.sv
// Self-checking bench for parity_frame_receiver: an even- and an odd-parity instance
// share stimulus; a queue-based frame model supplies the expected outputs.
module tb_parity_frame_receiver;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset, inBit, inValid, inStart, outReady;
  logic [WIDTH-1:0] data_e, data_o;
  logic             valid_e, valid_o, perr_e, perr_o, ovr_e, ovr_o;

  parity_frame_receiver #(.WIDTH(WIDTH), .ODD_PARITY(1'b0)) dut_even (
    .clk(clk), .reset(reset), .inBit(inBit), .inValid(inValid), .inStart(inStart),
    .outData(data_e), .outValid(valid_e), .outReady(outReady),
    .outParityErr(perr_e), .outOverrun(ovr_e)
  );

  parity_frame_receiver #(.WIDTH(WIDTH), .ODD_PARITY(1'b1)) dut_odd (
    .clk(clk), .reset(reset), .inBit(inBit), .inValid(inValid), .inStart(inStart),
    .outData(data_o), .outValid(valid_o), .outReady(outReady),
    .outParityErr(perr_o), .outOverrun(ovr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rst, v, s, b, rdy;
    logic             exp_valid;
    logic [WIDTH-1:0] exp_data;
    logic             exp_err_even, exp_err_odd, exp_ovr;
  } vec_t;

  vec_t  vecs[$];
  int    n_pass = 0;
  int    n_total = 0;
  int    valid_seen = 0;
  string cur_test = "init";

  // Reference model: frame bits collected in a queue, word packed on completion.
  logic             m_active = 1'b0;
  logic             m_bits[$];
  logic             m_valid = 1'b0;
  logic [WIDTH-1:0] m_data = '0;
  logic             m_err_e = 1'b0;
  logic             m_err_o = 1'b0;
  logic             m_ovr = 1'b0;

  function automatic void add_vec(input logic rst, v, s, b, rdy, ev,
                                  input logic [WIDTH-1:0] ed, input logic ee, eo, eov);
    vec_t t;
    t.rst = rst; t.v = v; t.s = s; t.b = b; t.rdy = rdy;
    t.exp_valid = ev; t.exp_data = ed;
    t.exp_err_even = ee; t.exp_err_odd = eo; t.exp_ovr = eov;
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic model_step(input logic rst, v, s, b, rdy);
    logic             done;
    logic             par;
    logic [WIDTH-1:0] word;
    done = 1'b0; par = 1'b0; word = '0;
    if (rst) begin
      m_active = 1'b0; m_bits.delete();
      m_valid = 1'b0; m_data = '0; m_err_e = 1'b0; m_err_o = 1'b0; m_ovr = 1'b0;
    end else begin
      if (v) begin
        if (s) begin
          m_bits.delete();
          m_bits.push_back(b);
          m_active = 1'b1;
        end else if (m_active) begin
          m_bits.push_back(b);
          if (m_bits.size() == WIDTH + 1) begin
            for (int i = 0; i < WIDTH; i++) word[i] = m_bits[i];
            foreach (m_bits[i]) par = par ^ m_bits[i];
            done = 1'b1;
            m_active = 1'b0;
          end
        end
      end
      if (done) begin
        if (!m_valid || rdy) begin
          m_valid = 1'b1; m_data = word; m_err_e = par; m_err_o = ~par;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, v, s, b, rdy);
    reset = rst; inValid = v; inStart = s; inBit = b; outReady = rdy;
    model_step(rst, v, s, b, rdy);
    @(posedge clk);
    #1;
    if (valid_e) valid_seen++;
  endtask

  task automatic checkOutput();
    check({cur_test, ".valid_e"}, valid_e, m_valid);
    check({cur_test, ".data_e"}, data_e, m_data);
    check({cur_test, ".perr_e"}, perr_e, m_err_e);
    check({cur_test, ".ovr_e"}, ovr_e, m_ovr);
    check({cur_test, ".valid_o"}, valid_o, m_valid);
    check({cur_test, ".data_o"}, data_o, m_data);
    check({cur_test, ".perr_o"}, perr_o, m_err_o);
    check({cur_test, ".ovr_o"}, ovr_o, m_ovr);
  endtask

  task automatic step(input logic rst, v, s, b, rdy);
    applyStimulus(rst, v, s, b, rdy);
    checkOutput();
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] word, input logic par,
                            input logic rdy, input int max_gap);
    for (int i = 0; i <= WIDTH; i++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(1, max_gap)) : 0;
      if (i > 0) repeat (gap) step(1'b0, 1'b0, 1'b0, 1'b0, rdy);
      if (i < WIDTH) step(1'b0, 1'b1, (i == 0), word[i], rdy);
      else           step(1'b0, 1'b1, 1'b0, par, rdy);
    end
  endtask

  task automatic report(input string name, input int bad_before);
    int bad_now;
    bad_now = n_total - n_pass;
    if (bad_now == bad_before) $display("[TB] %s PASSED", name);
    else $display("[TB] %s: %0d bad checks", name, bad_now - bad_before);
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    int               bad0;
    reset = 1'b1; inValid = 1'b0; inStart = 1'b0; inBit = 1'b0; outReady = 1'b0;

    // T0 reset, T1 A5/parity 0, T2 A5/parity 1, each followed by an accept cycle
    w = 8'hA5;
    add_vec(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    add_vec(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < WIDTH; i++) add_vec(0, 1, (i == 0), w[i], 1, 0, 8'h00, 0, 0, 0);
    add_vec(0, 1, 0, 0, 1, 1, 8'hA5, 0, 1, 0);
    add_vec(0, 0, 0, 0, 1, 0, 8'hA5, 0, 1, 0);
    for (int i = 0; i < WIDTH; i++) add_vec(0, 1, (i == 0), w[i], 1, 0, 8'hA5, 0, 1, 0);
    add_vec(0, 1, 0, 1, 1, 1, 8'hA5, 1, 0, 0);
    add_vec(0, 0, 0, 0, 1, 0, 8'hA5, 1, 0, 0);

    bad0 = 0;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].v, vecs[i].s, vecs[i].b, vecs[i].rdy);
      check($sformatf("T012[%0d].valid_e", i), valid_e, vecs[i].exp_valid);
      check($sformatf("T012[%0d].data_e", i), data_e, vecs[i].exp_data);
      check($sformatf("T012[%0d].perr_e", i), perr_e, vecs[i].exp_err_even);
      check($sformatf("T012[%0d].ovr_e", i), ovr_e, vecs[i].exp_ovr);
      check($sformatf("T012[%0d].valid_o", i), valid_o, vecs[i].exp_valid);
      check($sformatf("T012[%0d].data_o", i), data_o, vecs[i].exp_data);
      check($sformatf("T012[%0d].perr_o", i), perr_o, vecs[i].exp_err_odd);
    end
    report("T0-T2", bad0);

    // T3: overrun while the consumer stalls
    bad0 = n_total - n_pass;
    cur_test = "T3";
    send_frame(8'h0F, 1'b0, 1'b0, 0);
    check("T3.first_valid", valid_e, 1'b1);
    check("T3.first_data", data_e, 8'h0F);
    send_frame(8'hF0, 1'b0, 1'b0, 0);
    check("T3.held_data", data_e, 8'h0F);
    check("T3.overrun", ovr_e, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("T3.valid_drop", valid_e, 1'b0);
    check("T3.overrun_sticky", ovr_e, 1'b1);
    report("T3", bad0);

    // T4: aborted partial frame, restarted frame with gaps
    bad0 = n_total - n_pass;
    cur_test = "T4";
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    valid_seen = 0;
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b1, 3);
    check("T4.data", data_e, 8'h3C);
    check("T4.perr", perr_e, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("T4.single_valid", valid_seen, 1);
    report("T4", bad0);

    // T5: reset mid-frame, then orphan bits without a start
    bad0 = n_total - n_pass;
    cur_test = "T5";
    w = 8'h5A;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, (i == 0), w[i], 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    valid_seen = 0;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("T5.no_valid", valid_seen, 0);
    send_frame(8'h81, 1'b0, 1'b1, 1);
    check("T5.valid", valid_e, 1'b1);
    check("T5.data", data_e, 8'h81);
    check("T5.perr", perr_e, 1'b0);
    report("T5", bad0);

    // Randomized traffic: whole frames plus raw noisy bit streams
    bad0 = n_total - n_pass;
    cur_test = "RND";
    for (int f = 0; f < 30; f++) begin
      send_frame(WIDTH'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
      if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    for (int c = 0; c < 600; c++) begin
      logic r, v, s;
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 3) != 0);
      s = v && ($urandom_range(0, 19) == 0);
      step(r, v, s, 1'($urandom), 1'($urandom));
    end
    report("RND", bad0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
